// File: rtl/memory_pkg.sv
// ============================================================================
// memory_pkg
// Shared FSM state encoding and read-latency limits for memory_pipelined.
// Revision: 1.0
// ============================================================================
`default_nettype none

package memory_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int C_RD_LAT_MIN = 1;
    localparam int C_RD_LAT_MAX = 4;

endpackage

`default_nettype wire

// File: rtl/mem_rd_pipe.sv
// ============================================================================
// mem_rd_pipe
// Read-latency delay line carrying response valid and data to the output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_rd_pipe #(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    logic [READ_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

    // Data is zeroed at entry, so every stage holds zero whenever its valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_valid_i;
            dat_q[0] <= in_valid_i ? in_data_i : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_valid_o = vld_q[READ_LATENCY-1];
    assign out_data_o  = dat_q[READ_LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/memory_pipelined.sv
// ============================================================================
// memory_pipelined
// Byte-writable single-port memory with post-reset clear sweep and fixed read latency.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memory_pipelined #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    busy
);

    import memory_pkg::*;

    localparam int DEPTH  = 2 ** ADDR_WIDTH;
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    localparam logic   RESET_BUSY  = (CLEAR_ON_RESET != 0);

    generate
        if ((DATA_WIDTH % 8) != 0 || READ_LATENCY < C_RD_LAT_MIN
                || READ_LATENCY > C_RD_LAT_MAX) begin : g_param_check
            $error("memory_pipelined: illegal DATA_WIDTH or READ_LATENCY");
        end
    endgenerate

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   ptr_q;
    logic                    ready_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    accept;
    logic                    wr_accept;
    logic                    rd_accept;
    logic                    clear_wr;
    logic [DATA_WIDTH-1:0]   rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
            ptr_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= RESET_BUSY;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    ptr_q   <= ptr_q + 1'b1;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                    if (ptr_q == LAST_ADDR) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                ST_READY: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // A request coinciding with a reset edge is dropped, even if ready was high.
    assign accept    = req_valid && ready_q && !rst;
    assign wr_accept = accept && req_write;
    assign rd_accept = accept && !req_write;
    assign clear_wr  = (state_q == ST_CLEAR) && !rst;
    assign rd_data   = mem_q[address];

    always_ff @(posedge clk) begin
        if (clear_wr) begin
            mem_q[ptr_q] <= '0;
        end else if (wr_accept) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (byte_en[b]) begin
                    mem_q[address][b*8 +: 8] <= data_in[b*8 +: 8];
                end
            end
        end
    end

    mem_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (rd_accept),
        .in_data_i   (rd_data),
        .out_valid_o (resp_valid),
        .out_data_o  (data_out)
    );

    assign req_ready = ready_q;
    assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_pipelined.sv
// ============================================================================
// tb_memory_pipelined
// Scoreboard bench for memory_pipelined (32-bit words, read latency 3).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_memory_pipelined;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int RL    = 3;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_in = '0;
    logic [3:0]    byte_en = '0;
    logic          resp_valid;
    logic [DW-1:0] data_out;
    logic          busy;

    memory_pipelined #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .READ_LATENCY   (RL),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .address    (address),
        .data_in    (data_in),
        .byte_en    (byte_en),
        .resp_valid (resp_valid),
        .data_out   (data_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every response must match the oldest outstanding read, on its due cycle.
    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_cycle", 32'(cyc), 32'(e.due));
                check("resp_data", data_out, e.data);
            end
        end else begin
            check("idle_data_zero", data_out, 32'd0);
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                void'(exp_q.pop_front());
                check("missed_resp", 32'd0, 32'd1);
            end
        end
    end

    // One request per call; the model acts only if the DUT will accept it at the next edge.
    task automatic drive(input logic v, input logic w, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        exp_t e;
        @(posedge clk);
        #1;
        req_valid = v;
        req_write = w;
        address   = a;
        data_in   = d;
        byte_en   = be;
        if (v && req_ready === 1'b1 && !rst) begin
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[a][b*8 +: 8] = d[b*8 +: 8];
            end else begin
                e.due  = cyc + RL;
                e.data = model_mem[a];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst       = 1'b1;
        req_valid = 1'b0;
        while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_resp_valid", 32'(resp_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic sweep_check();
        int n;
        int bad;
        n   = 0;
        bad = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 40) begin
            if (req_ready !== 1'b0) bad++;
            n++;
            @(negedge clk);
        end
        check("sweep_len", 32'(n), 32'd16);
        check("ready_in_clear", 32'(bad), 32'd0);
        check("ready_after_clear", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

        do_reset(3);
        sweep_check();

        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 4'(i), 32'd0, 4'd0);
        idle(2);

        drive(1'b1, 1'b1, 4'd0, 32'h0000_00AA, 4'hF);
        drive(1'b1, 1'b1, 4'd1, 32'h0000_0055, 4'hF);
        drive(1'b1, 1'b0, 4'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 4'd1, 32'd0, 4'd0);
        idle(5);

        drive(1'b1, 1'b1, 4'd3, 32'h1122_3344, 4'hF);
        drive(1'b1, 1'b1, 4'd3, 32'hFFFF_FFFF, 4'b0101);
        drive(1'b1, 1'b0, 4'd3, 32'd0, 4'd0);
        idle(4);

        drive(1'b1, 1'b1, 4'd2, 32'h0000_0077, 4'hF);
        drive(1'b1, 1'b0, 4'd2, 32'd0, 4'd0);
        drive(1'b1, 1'b1, 4'd2, 32'hDEAD_BEEF, 4'h0);
        drive(1'b1, 1'b0, 4'd2, 32'd0, 4'd0);
        idle(4);

        repeat (300) begin
            drive(($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
                  $urandom, 4'($urandom));
        end
        idle(6);

        // Two reads still in the pipe when reset hits must never respond.
        drive(1'b1, 1'b0, 4'd0, 32'd0, 4'd0);
        drive(1'b1, 1'b0, 4'd1, 32'd0, 4'd0);
        do_reset(2);

        // Interrupt the sweep at address 5, then retry writes during the restarted sweep.
        repeat (5) drive(1'b1, 1'b1, 4'd4, 32'h0000_0099, 4'hF);
        do_reset(2);
        fork
            sweep_check();
            begin
                repeat (8) drive(1'b1, 1'b1, 4'd4, 32'h0000_0099, 4'hF);
                idle(1);
            end
        join
        drive(1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
        idle(1);

        begin
            int n;
            n = 0;
            while (exp_q.size() > 0 && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("drain_outstanding", 32'(exp_q.size()), 32'd0);
        end
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_pipelined.md
MEMORY_PIPELINED -- requirements
Module: memory_pipelined

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, address bits; depth = 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, word bits; must be a multiple of 8.
REQ-003 SHALL have parameter READ_LATENCY, default 1, cycles from read acceptance to resp_valid; legal range 1..4.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero every word after reset, 0 = no clear.
REQ-005 SHALL have one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1 bit, single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port req_valid, input, 1 bit, request present.
REQ-009 SHALL have port req_ready, output, 1 bit, block accepts a request this cycle.
REQ-010 SHALL have port req_write, input, 1 bit, 1 = write, 0 = read.
REQ-011 SHALL have port address, input, ADDR_WIDTH bits, word address.
REQ-012 SHALL have port data_in, input, DATA_WIDTH bits, write data.
REQ-013 SHALL have port byte_en, input, DATA_WIDTH/8 bits, per-byte write enable.
REQ-014 SHALL have port resp_valid, output, 1 bit, one-cycle pulse per read response.
REQ-015 SHALL have port data_out, output, DATA_WIDTH bits, read data.
REQ-016 SHALL have port busy, output, 1 bit, clear sweep in progress.

Function
REQ-017 SHALL run a two-state FSM: CLEAR and READY.
REQ-018 SHALL, in CLEAR, write zero to one word per cycle, ascending from address 0, holding req_ready=0 and busy=1.
REQ-019 SHALL move CLEAR -> READY in the cycle after the write to address 2**ADDR_WIDTH-1, so the sweep takes exactly 2**ADDR_WIDTH cycles.
REQ-020 SHALL, when CLEAR_ON_RESET=0, enter READY directly from reset, with memory contents undefined.
REQ-021 SHALL, in READY, drive req_ready=1 and busy=0.
REQ-022 SHALL accept a request on a rising edge where req_valid && req_ready; otherwise ignore all request inputs.
REQ-023 SHALL, on an accepted write, update at that edge only the bytes whose byte_en bit is 1; write produces no response.
REQ-024 SHALL, on an accepted read, assert resp_valid for exactly one cycle, READ_LATENCY cycles after acceptance, with data_out = word content at acceptance edge.
REQ-025 SHALL sustain one accepted request per cycle; back-to-back reads produce back-to-back responses in request order.
REQ-026 SHALL return the new data for a read accepted on the cycle after a write to the same address.
REQ-027 SHALL drive data_out to all zeros whenever resp_valid=0.
REQ-028 SHALL treat byte_en=0 on a write as an accepted no-op.

Reset
REQ-029 SHALL, on rst=1 at a rising edge, set req_ready=0, resp_valid=0, data_out=0, flush all in-flight reads, and set the clear pointer to 0.
REQ-030 SHALL, when rst falls, enter CLEAR with busy=1 if CLEAR_ON_RESET=1, else READY with busy=0.
REQ-031 SHALL, on reset during a CLEAR sweep, restart the sweep from address 0.
REQ-032 SHALL, on reset with reads in flight, produce none of those responses.

Structure
REQ-033 SHALL place the FSM state enum (CLEAR, READY) and the READ_LATENCY range limits in package memory_pkg.
REQ-034 SHALL implement the read-latency valid/data shift stage as sub-module mem_rd_pipe, parameterised by DATA_WIDTH and READ_LATENCY.
REQ-035 SHALL reject illegal parameters (DATA_WIDTH%8 != 0, or READ_LATENCY outside 1..4) with an elaboration-time assertion.

Verification
REQ-036 Defaults, reset released -> busy=1, req_ready=0 for 16 cycles, then req_ready=1; reads of addresses 0..15 all return 0x00.
REQ-037 Write 0xAA @0, write 0x55 @1, read 0, read 1 back-to-back -> resp_valid pulses on consecutive cycles with 0xAA then 0x55; data_out=0x00 on the cycle after.
REQ-038 DATA_WIDTH=32: write 0x11223344 @3 with byte_en=1111, then write 0xFFFFFFFF @3 with byte_en=0101 -> read @3 returns 0x11FF33FF.
REQ-039 READ_LATENCY=3: read @0 accepted at cycle N -> resp_valid=1 only at N+3; write 0x77 @2 followed next cycle by read @2 -> returns 0x77.
REQ-040 Assert rst with two reads in flight and the sweep at address 5 -> no resp_valid; after release, sweep restarts at 0 and takes the full 16 cycles.
REQ-041 req_valid=1 during CLEAR with a write of 0x99 @4 -> ignored; after the sweep, read @4 returns 0x00.
